// File: rtl/sr_latch_driver_pkg.sv
// Shared types and widths for the NAND SR latch driver.
package sr_drv_pkg;

  localparam int unsigned CntW    = 4;
  localparam int unsigned ErrCntW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StPulse,
    StGap,
    StCheck
  } state_e;

endpackage

// File: rtl/sr_latch_driver_if.sv
// Command handshake, latch drive and latch feedback bundle for sr_latch_driver.
interface sr_latch_driver_if;
  import sr_drv_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_val;
  logic               set;
  logic               reset;
  logic               q;
  logic               qbar;
  logic               done;
  logic               err;
  logic [ErrCntW-1:0] err_cnt;

  modport master (
    output cmd_valid, cmd_val, q, qbar,
    input  cmd_ready, set, reset, done, err, err_cnt
  );

  modport slave (
    input  cmd_valid, cmd_val, q, qbar,
    output cmd_ready, set, reset, done, err, err_cnt
  );

endinterface

// File: rtl/sr_latch_driver_sync2.sv
// Two-flop synchronizer for one asynchronous feedback bit; resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/sr_latch_driver.sv
// Sequencer that pulses one active-low input of a NAND SR latch, waits a guard gap,
// then confirms the synchronized latch feedback against the requested value.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int unsigned PULSE_W = 3,
  parameter int unsigned GAP_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  sr_latch_driver_if.slave drv_bus
);

  localparam logic [CntW-1:0] PulseLd = CntW'(PULSE_W - 1);
  localparam logic [CntW-1:0] GapLd   = CntW'(GAP_W - 1);

  state_e             r_state, w_state_d;
  logic [CntW-1:0]    r_cnt, w_cnt_d;
  logic               r_tgt, w_tgt_d;
  logic               r_set, w_set_d;
  logic               r_reset, w_reset_d;
  logic [ErrCntW-1:0] r_err_cnt, w_err_cnt_d;
  logic               w_qs, w_qbs;
  logic               w_match;
  logic               w_done, w_err;

  sync2 u_sync_q (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (drv_bus.q),
    .o_q   (w_qs)
  );

  sync2 u_sync_qbar (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (drv_bus.qbar),
    .o_q   (w_qbs)
  );

  assign w_match = (w_qs == r_tgt) && (w_qbs == ~r_tgt);

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_tgt_d     = r_tgt;
    w_err_cnt_d = r_err_cnt;
    w_done      = 1'b0;
    w_err       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (drv_bus.cmd_valid) begin
          w_tgt_d   = drv_bus.cmd_val;
          w_cnt_d   = PulseLd;
          w_state_d = StPulse;
        end
      end
      StPulse: begin
        if (r_cnt == '0) begin
          w_cnt_d   = GapLd;
          w_state_d = StGap;
        end else begin
          w_cnt_d = r_cnt - CntW'(1);
        end
      end
      StGap: begin
        if (r_cnt == '0) begin
          w_state_d = StCheck;
        end else begin
          w_cnt_d = r_cnt - CntW'(1);
        end
      end
      StCheck: begin
        w_state_d = StIdle;
        if (w_match) begin
          w_done = 1'b1;
        end else begin
          w_err = 1'b1;
          if (r_err_cnt != '1) begin
            w_err_cnt_d = r_err_cnt + ErrCntW'(1);
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
    // Drive from the next state so the registered pulse lines up with the state;
    // only one of the two inputs can ever be selected.
    w_set_d   = !((w_state_d == StPulse) && !w_tgt_d);
    w_reset_d = !((w_state_d == StPulse) && w_tgt_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_tgt     <= 1'b0;
      r_set     <= 1'b1;
      r_reset   <= 1'b1;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_tgt     <= w_tgt_d;
      r_set     <= w_set_d;
      r_reset   <= w_reset_d;
      r_err_cnt <= w_err_cnt_d;
    end
  end

  assign drv_bus.cmd_ready = (r_state == StIdle);
  assign drv_bus.set       = r_set;
  assign drv_bus.reset     = r_reset;
  assign drv_bus.done      = w_done;
  assign drv_bus.err       = w_err;
  assign drv_bus.err_cnt   = r_err_cnt;

endmodule

// File: doc/sr_latch_driver.md
# sr_latch_driver

Synchronous command sequencer that drives the active-low set/reset inputs of the cross-coupled NAND SR latch and confirms the result from the latch outputs. A single-command valid/ready handshake selects the target state. The driver issues a bounded low pulse on exactly one latch input and then holds both inputs high through a guard gap. It samples the synchronized `q`/`qbar` feedback and reports done or error. The block sits between clocked control logic and the asynchronous latch, so the latch is never driven into its forbidden both-low input state.

## Interface
- `PULSE_W`, default 3: cycles the selected latch input is held low; legal range 1..15.
- `GAP_W`, default 3: cycles with both inputs high before the check; legal range 3..15, to cover gate delay plus synchronizer.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  driver idle and able to accept a command.
- `cmd_val`  in  1  target latch value: 1 means `q`=1, 0 means `q`=0.
- `set`  out  1  to latch `set`; low forces `qbar`=1, which clears `q`.
- `reset`  out  1  to latch `reset`; low forces `q`=1.
- `q`, `qbar`  in  1 each  asynchronous latch feedback.
- `done`  out  1  one-cycle pulse: the latch reached the target value.
- `err`  out  1  one-cycle pulse: the latch feedback mismatched the target.
- `err_cnt`  out  8  saturating error count.

## Operation
- Reset values:
  - `set`=1, `reset`=1
  - `cmd_ready`=1
  - `done`=0, `err`=0
  - `err_cnt`=0
  - state IDLE
  - `q`/`qbar` synchronizer flops = 0
- `set` and `reset` are registered outputs.
- FSM states and transitions:
  - IDLE: `cmd_ready`=1, both outputs high. `cmd_valid & cmd_ready` captures `cmd_val` into `tgt`, loads the counter with PULSE_W-1, and moves to PULSE.
  - PULSE: `reset`=0 if `tgt`=1, otherwise `set`=0. The counter decrements each cycle. At 0 it loads GAP_W-1 and moves to GAP.
  - GAP: both outputs high. At counter 0 the FSM moves to CHECK.
  - CHECK: compare the synchronized values `qs`, `qbs`. If `qs`==`tgt` and `qbs`==~`tgt`, pulse `done`. Otherwise pulse `err` and increment `err_cnt`, which saturates at 255. The FSM then returns to IDLE.
- `set` and `reset` are never low in the same cycle, by construction. This is an assertion target.
- A command whose target equals the current latch value still executes the full sequence.
- `cmd_valid` outside IDLE is ignored. Nothing is queued.
- `q`/`qbar` pass through a two-flop synchronizer. Only the synchronized values are used.
- Asynchronous reset mid-operation:
  - `set` and `reset` go high immediately and the FSM returns to IDLE.
  - The latch keeps whatever value it holds; the driver takes no corrective action.
  - `err_cnt` clears.

## Timing
- Cycle 0 is the handshake edge.
- Latch input low during cycles 1..PULSE_W.
- Gap during cycles PULSE_W+1..PULSE_W+GAP_W.
- CHECK, and `done` or `err`, at cycle PULSE_W+GAP_W+1.
- `cmd_ready` is low from cycle 1 through CHECK and high again at cycle PULSE_W+GAP_W+2.
- With the defaults:
  - pulse in cycles 1–3
  - gap in cycles 4–6
  - `done`/`err` at cycle 7
  - next command accepted at cycle 8
  - throughput is one command per 8 cycles
- `done` and `err` are mutually exclusive and last exactly one cycle.

## Structure
- Package `sr_drv_pkg`:
  - state enum (IDLE, PULSE, GAP, CHECK)
  - counter width constant (4 bits)
  - `err_cnt` width constant (8)
- Sub-module `sync2`: two-flop synchronizer, instanced once per feedback bit.
- Top-level contains the FSM, the counter, and the error counter.

## Test plan
Use a clock period of 10 time units, with `sr_latch_driver` connected to a NAND latch model that has 1-unit gate delays.
- Reset: hold `rst_n`=0, release → `set`=1, `reset`=1, `cmd_ready`=1, `done`=0, `err`=0, `err_cnt`=0.
- `cmd_val`=1 accepted at cycle 0 → `reset` low in cycles 1–3 with `set` high throughout; `done` at cycle 7; `q`=1, `qbar`=0; `cmd_ready` high at cycle 8.
- Then `cmd_val`=0 → `set` low for 3 cycles; `done` at cycle 7; `q`=0.
- Fault: force `q`=0 and `qbar`=1, then send `cmd_val`=1 → `err` at cycle 7, `err_cnt`=1. After 300 such commands `err_cnt`=255.
- Reset mid-PULSE: drop `rst_n` in cycle 2 → `set` and `reset` high before the next edge; after release `cmd_ready`=1 with no `done` and no `err`.
- Back-to-back: hold `cmd_valid`=1 with alternating `cmd_val` over 10 commands → commands accepted every 8 cycles, 10 `done` pulses, and `set` and `reset` never low together.
